pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port controlWord, input, 31 bits: {Psel[30:29], DA[28:24], SA[23:19], SB[18:14], Fsel[13:9], regW[8], ramW[7], EN_MEM[6], EN_ALU[5], EN_B[4], EN_PC[3], Bsel[2], PCsel[1], SL[0]} from the active instruction decoder.
REQ-004 SHALL have port nextState, input, 2 bits: next decoder state from the active decoder.
REQ-005 SHALL have port K, input, 64 bits: sign-extended branch offset in words.
REQ-006 SHALL have port in, input, 64 bits: data bus value, used as register-indirect branch target.
REQ-007 SHALL have port imem_data, input, 32 bits: instruction memory read data.
REQ-008 SHALL have port imem_ready, input, 1 bit: imem_data valid this cycle.
REQ-009 SHALL have port PC, output, 64 bits: current program counter, also the instruction memory address.
REQ-010 SHALL have port PC4, output, 64 bits: combinational PC+4, placed on the data bus by the datapath when EN_PC=1.
REQ-011 SHALL have port instruction, output, 32 bits: registered instruction register (IR).
REQ-012 SHALL have port state, output, 2 bits: registered decoder state.
REQ-013 SHALL have port imem_req, output, 1 bit: high while in FETCH.
REQ-014 SHALL have port exec, output, 1 bit: high while in EXEC; the datapath gates regW/ramW with it.
REQ-015 SHALL have port branch_taken, output, 1 bit: registered one-cycle pulse after a PC load with Psel=10 or 11.

Function
REQ-016 SHALL implement a two-state FSM, FETCH and EXEC.
REQ-017 In FETCH with imem_ready=0, SHALL hold PC, IR, state and FSM; imem_req=1.
REQ-018 In FETCH with imem_ready=1, SHALL latch imem_data into IR, set state to 00 and move to EXEC.
REQ-019 In EXEC, SHALL ignore imem_ready and imem_data and register state <= nextState every cycle.
REQ-020 In EXEC with nextState != 00, SHALL stay in EXEC and hold PC (multi-cycle instruction).
REQ-021 In EXEC with nextState = 00, SHALL update PC per Psel and return to FETCH.
REQ-022 Psel decode at the final EXEC cycle: 00 -> PC held; 01 -> PC+4; 10 -> in; 11 -> PC+4+(K<<2).
REQ-023 All PC arithmetic SHALL be 64-bit modulo 2^64; K<<2 drops K[63:62]; no overflow flag.
REQ-024 PC4 SHALL equal PC+4 mod 2^64 at all times, independent of FSM state.
REQ-025 branch_taken SHALL be 1 in the cycle after a PC update with Psel[1]=1, and 0 otherwise.
REQ-026 Non-Psel controlWord fields SHALL be ignored by this block.
REQ-027 SHALL contain no combinational path from imem_data to PC, state or exec.

Reset
REQ-028 reset=1 SHALL immediately force PC=0, IR=0, state=00, FSM=FETCH, branch_taken=0, regardless of clock or FSM state.
REQ-029 Reset asserted mid-EXEC SHALL abandon the instruction without any PC update.
REQ-030 After reset deassertion, first fetch SHALL be from PC=0.

Verification
REQ-031 Reset, then imem_ready=1 with imem_data=0xB4000040, then Psel=11, K=2, nextState=00 -> PC=0x0C, branch_taken=1 for one cycle, FSM=FETCH.
REQ-032 Sequential fetch: Psel=01, nextState=00 for three instructions with imem_ready=1 -> PC goes 0, 4, 8, 0xC; exec high one cycle per instruction.
REQ-033 Stall: imem_ready=0 for 5 cycles in FETCH -> PC, IR, state unchanged; imem_req=1 throughout; EXEC entered on the cycle after imem_ready=1.
REQ-034 Multi-cycle: nextState sequence 01, 10, 00 with Psel=10, in=0x1000 -> state goes 01, 10, 00; PC=0x1000 only after the third EXEC cycle.
REQ-035 Wrap and negative offset: PC=0xFFFFFFFFFFFFFFFC, Psel=01 -> PC=0; then K=-1 (all ones), Psel=11 -> PC=0 (PC+4-4).
REQ-036 Reset pulse mid-EXEC with nextState=01 -> PC=0, state=00, FSM=FETCH immediately, with no clock edge required.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction per FETCH/EXEC round trip.
// It holds the IR and decoder state and applies the Psel-selected PC update when an instruction finishes.
module pc_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic [30:0] controlWord,
    input  logic [1:0]  nextState,
    input  logic [63:0] K,
    input  logic [63:0] in,
    input  logic [31:0] imem_data,
    input  logic        imem_ready,
    output logic [63:0] PC,
    output logic [63:0] PC4,
    output logic [31:0] instruction,
    output logic [1:0]  state,
    output logic        imem_req,
    output logic        exec,
    output logic        branch_taken
);

    typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} fsm_t;

    fsm_t        fsm_q, fsm_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  state_q, state_d;
    logic        bt_q, bt_d;

    logic [1:0]  psel;
    logic [63:0] pc4;
    logic [63:0] branch_target;
    logic        unused_ctrl;

    assign psel          = controlWord[30:29];
    assign pc4           = pc_q + 64'd4;
    // K is a word offset; the shift discards K[63:62] by construction.
    assign branch_target = pc4 + {K[61:0], 2'b00};
    assign unused_ctrl   = ^{controlWord[28:0], K[63:62]};

    always_comb begin
        fsm_d   = fsm_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        state_d = state_q;
        bt_d    = 1'b0;
        case (fsm_q)
            FETCH: begin
                if (imem_ready) begin
                    ir_d    = imem_data;
                    state_d = 2'b00;
                    fsm_d   = EXEC;
                end
            end
            EXEC: begin
                state_d = nextState;
                // Only the final cycle of an instruction moves the PC.
                if (nextState == 2'b00) begin
                    fsm_d = FETCH;
                    bt_d  = psel[1];
                    case (psel)
                        2'b00:   pc_d = pc_q;
                        2'b01:   pc_d = pc4;
                        2'b10:   pc_d = in;
                        default: pc_d = branch_target;
                    endcase
                end
            end
            default: fsm_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= FETCH;
            pc_q    <= 64'd0;
            ir_q    <= 32'd0;
            state_q <= 2'b00;
            bt_q    <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            state_q <= state_d;
            bt_q    <= bt_d;
        end
    end

    assign PC           = pc_q;
    assign PC4          = pc4;
    assign instruction  = ir_q;
    assign state        = state_q;
    assign imem_req     = (fsm_q == FETCH);
    assign exec         = (fsm_q == EXEC);
    assign branch_taken = bt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a vector table for the main flow, plus hand-written
// sequences for sequential fetch, stall, and asynchronous reset.
module tb_pc_sequencer;

    logic        clock;
    logic        reset;
    logic [30:0] controlWord;
    logic [1:0]  nextState;
    logic [63:0] K;
    logic [63:0] in_v;
    logic [31:0] imem_data;
    logic        imem_ready;
    logic [63:0] PC;
    logic [63:0] PC4;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic        imem_req;
    logic        exec;
    logic        branch_taken;

    int total_cnt = 0;
    int pass_cnt  = 0;

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .controlWord  (controlWord),
        .nextState    (nextState),
        .K            (K),
        .in           (in_v),
        .imem_data    (imem_data),
        .imem_ready   (imem_ready),
        .PC           (PC),
        .PC4          (PC4),
        .instruction  (instruction),
        .state        (state),
        .imem_req     (imem_req),
        .exec         (exec),
        .branch_taken (branch_taken)
    );

    // Clock and reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rdy;
        logic [31:0] data;
        logic [1:0]  psel;
        logic [1:0]  ns;
        logic [63:0] k;
        logic [63:0] in_val;
        logic [63:0] e_pc;
        logic [31:0] e_ir;
        logic [1:0]  e_st;
        logic        e_exec;
        logic        e_bt;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic rdy, logic [31:0] data, logic [1:0] psel, logic [1:0] ns,
                                logic [63:0] k, logic [63:0] in_val, logic [63:0] e_pc,
                                logic [31:0] e_ir, logic [1:0] e_st, logic e_exec, logic e_bt);
        vec_t v;
        v.rdy = rdy; v.data = data; v.psel = psel; v.ns = ns; v.k = k; v.in_val = in_val;
        v.e_pc = e_pc; v.e_ir = e_ir; v.e_st = e_st; v.e_exec = e_exec; v.e_bt = e_bt;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_all(string tag, logic [63:0] e_pc, logic [31:0] e_ir, logic [1:0] e_st,
                           logic e_exec, logic e_bt);
        chk({tag, ".pc"},       PC,                  e_pc);
        chk({tag, ".pc4"},      PC4,                 e_pc + 64'd4);
        chk({tag, ".ir"},       64'(instruction),    64'(e_ir));
        chk({tag, ".state"},    64'(state),          64'(e_st));
        chk({tag, ".exec"},     64'(exec),           64'(e_exec));
        chk({tag, ".imem_req"}, 64'(imem_req),       64'(!e_exec));
        chk({tag, ".bt"},       64'(branch_taken),   64'(e_bt));
    endtask

    // Driver: inputs change on the falling edge; other controlWord bits are randomised
    // to show they have no effect.
    task automatic drive(logic rdy, logic [31:0] data, logic [1:0] psel, logic [1:0] ns,
                         logic [63:0] k, logic [63:0] in_val);
        @(negedge clock);
        imem_ready  = rdy;
        imem_data   = data;
        controlWord = {psel, 29'($urandom)};
        nextState   = ns;
        K           = k;
        in_v        = in_val;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] TOP  = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        reset       = 1'b1;
        imem_ready  = 1'b0;
        imem_data   = 32'd0;
        controlWord = 31'd0;
        nextState   = 2'b00;
        K           = 64'd0;
        in_v        = 64'd0;
        #1;
        chk_all("reset", 64'd0, 32'd0, 2'b00, 1'b0, 1'b0);

        //               rdy  data          psel   ns     K       in            e_pc        e_ir          e_st  ex  bt
        vecs[0]  = mk(1'b1, 32'hB4000040, 2'b00, 2'b00, 64'd0,  64'd0,        64'h0,      32'hB4000040, 2'd0, 1, 0);
        vecs[1]  = mk(1'b0, 32'h0,        2'b11, 2'b00, 64'd2,  64'd0,        64'hC,      32'hB4000040, 2'd0, 0, 1);
        vecs[2]  = mk(1'b0, 32'h12345678, 2'b11, 2'b00, 64'd2,  64'd0,        64'hC,      32'hB4000040, 2'd0, 0, 0);
        vecs[3]  = mk(1'b1, 32'h11111111, 2'b00, 2'b11, 64'd0,  64'd0,        64'hC,      32'h11111111, 2'd0, 1, 0);
        vecs[4]  = mk(1'b0, 32'h0,        2'b01, 2'b00, 64'd0,  64'd0,        64'h10,     32'h11111111, 2'd0, 0, 0);
        vecs[5]  = mk(1'b1, 32'h22222222, 2'b00, 2'b00, 64'd0,  64'd0,        64'h10,     32'h22222222, 2'd0, 1, 0);
        vecs[6]  = mk(1'b1, 32'hDEADBEEF, 2'b01, 2'b01, 64'd0,  64'd0,        64'h10,     32'h22222222, 2'd1, 1, 0);
        vecs[7]  = mk(1'b1, 32'hDEADBEEF, 2'b10, 2'b10, 64'd0,  64'h1000,     64'h10,     32'h22222222, 2'd2, 1, 0);
        vecs[8]  = mk(1'b0, 32'h0,        2'b10, 2'b00, 64'd0,  64'h1000,     64'h1000,   32'h22222222, 2'd0, 0, 1);
        vecs[9]  = mk(1'b1, 32'h33333333, 2'b00, 2'b00, 64'd0,  64'd0,        64'h1000,   32'h33333333, 2'd0, 1, 0);
        vecs[10] = mk(1'b0, 32'h0,        2'b10, 2'b00, 64'd0,  TOP,          TOP,        32'h33333333, 2'd0, 0, 1);
        vecs[11] = mk(1'b1, 32'h44444444, 2'b00, 2'b00, 64'd0,  64'd0,        TOP,        32'h44444444, 2'd0, 1, 0);
        vecs[12] = mk(1'b0, 32'h0,        2'b01, 2'b00, 64'd0,  64'd0,        64'h0,      32'h44444444, 2'd0, 0, 0);
        vecs[13] = mk(1'b1, 32'h55555555, 2'b00, 2'b00, 64'd0,  64'd0,        64'h0,      32'h55555555, 2'd0, 1, 0);
        vecs[14] = mk(1'b0, 32'h0,        2'b11, 2'b00, ONES,   64'd0,        64'h0,      32'h55555555, 2'd0, 0, 1);
        vecs[15] = mk(1'b1, 32'h66666666, 2'b00, 2'b00, 64'd0,  64'd0,        64'h0,      32'h66666666, 2'd0, 1, 0);
        vecs[16] = mk(1'b0, 32'h0,        2'b00, 2'b00, 64'd0,  64'h5000,     64'h0,      32'h66666666, 2'd0, 0, 0);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rdy, vecs[i].data, vecs[i].psel, vecs[i].ns, vecs[i].k, vecs[i].in_val);
            chk_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_st,
                    vecs[i].e_exec, vecs[i].e_bt);
        end

        // Sequential fetch from reset: 0, 4, 8, 0xC.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA0 + 32'(i), 2'b00, 2'b00, 64'd0, 64'd0);
            chk_all($sformatf("seq%0d.exec", i), 64'(4 * i), 32'hA0 + 32'(i), 2'd0, 1'b1, 1'b0);
            drive(1'b0, 32'h0, 2'b01, 2'b00, 64'd0, 64'd0);
            chk_all($sformatf("seq%0d.done", i), 64'(4 * (i + 1)), 32'hA0 + 32'(i), 2'd0, 1'b0, 1'b0);
        end

        // Stall in FETCH for five cycles, then accept.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'hBADBAD00 + 32'(i), 2'b11, 2'b10, 64'd7, 64'h9999);
            chk_all($sformatf("stall%0d", i), 64'hC, 32'hA2, 2'd0, 1'b0, 1'b0);
        end
        drive(1'b1, 32'hC0FFEE00, 2'b00, 2'b00, 64'd0, 64'd0);
        chk_all("stall.accept", 64'hC, 32'hC0FFEE00, 2'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-EXEC, no clock edge in between.
        drive(1'b0, 32'h0, 2'b11, 2'b01, 64'd5, 64'd0);
        chk_all("mid.exec", 64'hC, 32'hC0FFEE00, 2'd1, 1'b1, 1'b0);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async.reset", 64'd0, 32'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        chk_all("reset.hold", 64'd0, 32'd0, 2'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h0BADF00D, 2'b00, 2'b00, 64'd0, 64'd0);
        chk_all("post.reset", 64'd0, 32'h0BADF00D, 2'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
